// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: round-robin arbiter/sequencer sharing one combinational
// ECB core among NUM_REQ requesters; the winning key/block is registered onto
// the core and held CORE_LAT cycles, then the result returns via valid/ready.
// Ports: clk/rst (async, active-high); req_valid/req_ready/req_key/req_data
// (per-channel request, 128-bit slices); rsp_valid/rsp_ready/rsp_data (shared
// result bus); core_key/core_data_in/core_data_out (external core); busy;
// grant_id (channel currently served).
module aes_core_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int CORE_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*128-1:0]       req_key,
  input  logic [NUM_REQ*128-1:0]       req_data,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [127:0]                 rsp_data,
  output logic [127:0]                 core_key,
  output logic [127:0]                 core_data_in,
  input  logic [127:0]                 core_data_out,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           found;
  logic [3:0]     lat_cnt;

  logic [127:0]   key_arr  [NUM_REQ];
  logic [127:0]   data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign key_arr[i]  = req_key[i*128 +: 128];
    assign data_arr[i] = req_data[i*128 +: 128];
  end

  // Search starts just after the last served channel so a channel that keeps
  // requesting yields to every other pending channel before being served again.
  always_comb begin
    winner = last_grant;
    cand   = last_grant;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Ready is offered only while idle; reset forces it low immediately since
  // reset is asynchronous.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      core_key     <= '0;
      core_data_in <= '0;
      grant_id     <= '0;
      last_grant   <= IDW'(NUM_REQ - 1);
      lat_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            core_key     <= key_arr[winner];
            core_data_in <= data_arr[winner];
            grant_id     <= winner;
            last_grant   <= winner;
            lat_cnt      <= 4'(CORE_LAT - 1);
            state        <= WAIT;
          end
        end
        WAIT: begin
          // Core inputs stay untouched here: the core path is multicycle.
          if (lat_cnt == 4'd0) begin
            rsp_data            <= core_data_out;
            rsp_valid[grant_id] <= 1'b1;
            state               <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: directed-vector bench for aes_core_arbiter with a
// stand-in core (FIPS-197 vector plus a simple keyed mix for other blocks).
// Two instances: CORE_LAT=1 for arbitration/handshake, CORE_LAT=3 for latency.
module tb_aes_core_arbiter;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst;

  logic [1:0]   rv, rr, sv, sr;
  logic [255:0] rk, rd;
  logic [127:0] sd, ck, cdi, cdo;
  logic         bsy;
  logic [0:0]   gid;

  logic [1:0]   rv3, rr3, sv3, sr3;
  logic [255:0] rk3, rd3;
  logic [127:0] sd3, ck3, cdi3, cdo3;
  logic         bsy3;
  logic [0:0]   gid3;

  int           errors;
  int           checks;
  logic         fips_phase;
  logic         seen_v1;
  int           ec;
  int           cnt0, cnt1;
  logic [127:0] exp_d;
  logic [127:0] k0, d0, k1, d1;

  function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return {k[63:0] ^ d[127:64], k[127:64] + d[63:0]} ^ 128'h5a5a_0000_a5a5_ffff_1234_5678_9abc_def0;
  endfunction

  function automatic logic [127:0] blk_key(input int ch, input int n);
    return {32'hC0DE_0000 | 32'(ch), 32'(n), 64'h0F1E_2D3C_4B5A_6978 ^ 64'(ch * 16 + n)};
  endfunction

  function automatic logic [127:0] blk_data(input int ch, input int n);
    return {64'(n * 3 + ch), 32'hDA7A_0000 | 32'(ch), 32'(n + 100)};
  endfunction

  aes_core_arbiter #(.NUM_REQ(2), .CORE_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(rv), .req_ready(rr), .req_key(rk), .req_data(rd),
    .rsp_valid(sv), .rsp_ready(sr), .rsp_data(sd),
    .core_key(ck), .core_data_in(cdi), .core_data_out(cdo),
    .busy(bsy), .grant_id(gid)
  );

  aes_core_arbiter #(.NUM_REQ(2), .CORE_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(rv3), .req_ready(rr3), .req_key(rk3), .req_data(rd3),
    .rsp_valid(sv3), .rsp_ready(sr3), .rsp_data(sd3),
    .core_key(ck3), .core_data_in(cdi3), .core_data_out(cdo3),
    .busy(bsy3), .grant_id(gid3)
  );

  assign cdo  = core_model(ck, cdi);
  assign cdo3 = core_model(ck3, cdi3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fips_phase && sv[1]) seen_v1 = 1'b1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int n);
    if (ch == 0) begin
      rk[127:0] = blk_key(0, n);
      rd[127:0] = blk_data(0, n);
    end else begin
      rk[255:128] = blk_key(1, n);
      rd[255:128] = blk_data(1, n);
    end
  endtask

  initial begin
    errors = 0; checks = 0; fips_phase = 1'b0; seen_v1 = 1'b0;
    rst = 1'b1; rv = 2'b11; sr = 2'b00; rk = '0; rd = '0;
    rv3 = 2'b00; sr3 = 2'b00; rk3 = '0; rd3 = '0;

    // Reset values, with requests present (ready must stay low in reset)
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 128'(rr), 128'd0);
    chk("rst_rsp_valid", 128'(sv), 128'd0);
    chk("rst_rsp_data", sd, 128'd0);
    chk("rst_core_key", ck, 128'd0);
    chk("rst_core_data_in", cdi, 128'd0);
    chk("rst_busy", 128'(bsy), 128'd0);
    chk("rst_grant_id", 128'(gid), 128'd0);
    rv = 2'b00;
    rst = 1'b0;

    // FIPS-197 vector on channel 0
    @(negedge clk);
    fips_phase = 1'b1;
    rk[127:0] = FIPS_KEY; rd[127:0] = FIPS_PT; sr = 2'b11; rv = 2'b01;
    #1 chk("fips_req_ready", 128'(rr), 128'd1);
    @(negedge clk);
    rv = 2'b00;
    chk("fips_busy", 128'(bsy), 128'd1);
    chk("fips_grant", 128'(gid), 128'd0);
    chk("fips_core_key", ck, FIPS_KEY);
    chk("fips_core_data_in", cdi, FIPS_PT);
    chk("fips_no_early_valid", 128'(sv), 128'd0);
    @(negedge clk);
    chk("fips_rsp_valid", 128'(sv), 128'd1);
    chk("fips_rsp_data", sd, FIPS_CT);
    @(negedge clk);
    chk("fips_rsp_done", 128'(sv), 128'd0);
    chk("fips_idle", 128'(bsy), 128'd0);
    chk("fips_core_key_held", ck, FIPS_KEY);
    fips_phase = 1'b0;
    chk("fips_ch1_never_valid", 128'(seen_v1), 128'd0);

    // Back-pressure on channel 0 while channel 1 waits
    k0 = blk_key(0, 9); d0 = blk_data(0, 9);
    k1 = blk_key(1, 9); d1 = blk_data(1, 9);
    rk[127:0] = k0; rd[127:0] = d0; sr = 2'b00; rv = 2'b01;
    @(negedge clk);
    rk[255:128] = k1; rd[255:128] = d1; rv = 2'b10;
    #1 chk("bp_ready_wait", 128'(rr), 128'd0);
    @(negedge clk);
    exp_d = core_model(k0, d0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid_hold", 128'(sv), 128'd1);
      chk("bp_rsp_data_hold", sd, exp_d);
      chk("bp_ch1_ready_low", 128'(rr), 128'd0);
      @(negedge clk);
    end
    chk("bp_rsp_valid_still", 128'(sv), 128'd1);
    sr = 2'b01;
    @(negedge clk);
    chk("bp_rsp_released", 128'(sv), 128'd0);
    chk("bp_ch1_ready", 128'(rr), 128'd2);
    @(negedge clk);
    rv = 2'b00; sr = 2'b10;
    chk("bp_ch1_grant", 128'(gid), 128'd1);
    chk("bp_ch1_core_key", ck, k1);
    @(negedge clk);
    chk("bp_ch1_rsp_valid", 128'(sv), 128'd2);
    chk("bp_ch1_rsp_data", sd, core_model(k1, d1));
    @(negedge clk);
    chk("bp_ch1_done", 128'(sv), 128'd0);

    // Round-robin with both channels requesting 3 blocks each
    cnt0 = 0; cnt1 = 0;
    set_ch(0, 0); set_ch(1, 0); rv = 2'b11; sr = 2'b11;
    for (int b = 0; b < 6; b++) begin
      ec = b % 2;
      #1 chk("rr_ready", 128'(rr), (ec == 0) ? 128'd1 : 128'd2);
      exp_d = (ec == 0) ? core_model(rk[127:0], rd[127:0]) : core_model(rk[255:128], rd[255:128]);
      @(negedge clk);
      chk("rr_grant", 128'(gid), 128'(ec));
      if (ec == 0) begin
        cnt0++;
        if (cnt0 == 3) rv[0] = 1'b0; else set_ch(0, cnt0);
      end else begin
        cnt1++;
        if (cnt1 == 3) rv[1] = 1'b0; else set_ch(1, cnt1);
      end
      @(negedge clk);
      chk("rr_rsp_valid", 128'(sv), (ec == 0) ? 128'd1 : 128'd2);
      chk("rr_rsp_data", sd, exp_d);
      @(negedge clk);
    end

    // Self re-request: ch1 continuous, ch0 arrives during ch1's RESP
    k1 = blk_key(1, 20); d1 = blk_data(1, 20);
    rk[255:128] = k1; rd[255:128] = d1; rv = 2'b10;
    #1 chk("self_ch1_ready", 128'(rr), 128'd2);
    @(negedge clk);
    chk("self_ready_in_wait", 128'(rr), 128'd0);
    @(negedge clk);
    k0 = blk_key(0, 20); d0 = blk_data(0, 20);
    rk[127:0] = k0; rd[127:0] = d0; rv = 2'b11;
    #1 chk("self_ready_in_resp", 128'(rr), 128'd0);
    chk("self_ch1_rsp", sd, core_model(k1, d1));
    @(negedge clk);
    chk("self_ch0_next", 128'(rr), 128'd1);
    @(negedge clk);
    rv = 2'b10;
    chk("self_ch0_grant", 128'(gid), 128'd0);
    @(negedge clk);
    chk("self_ch0_rsp_valid", 128'(sv), 128'd1);
    chk("self_ch0_rsp_data", sd, core_model(k0, d0));
    @(negedge clk);
    chk("self_ch1_again", 128'(rr), 128'd2);
    @(negedge clk);
    rv = 2'b00;
    chk("self_ch1_grant", 128'(gid), 128'd1);
    @(negedge clk);
    @(negedge clk);

    // Reset while ch0 is in WAIT
    rk[127:0] = blk_key(0, 30); rd[127:0] = blk_data(0, 30); rv = 2'b01;
    @(negedge clk);
    rv = 2'b00;
    chk("mid_busy", 128'(bsy), 128'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(bsy), 128'd0);
    chk("mid_rst_core_key", ck, 128'd0);
    chk("mid_rst_core_data_in", cdi, 128'd0);
    chk("mid_rst_rsp_valid", 128'(sv), 128'd0);
    chk("mid_rst_rsp_data", sd, 128'd0);
    chk("mid_rst_grant", 128'(gid), 128'd0);
    @(negedge clk);
    chk("mid_no_rsp_in_rst", 128'(sv), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_rsp_after", 128'(sv), 128'd0);
    rv = 2'b11;
    #1 chk("mid_ch0_first", 128'(rr), 128'd1);
    rv = 2'b00;

    // Latency scaling: CORE_LAT=3 instance
    k0 = blk_key(0, 40); d0 = blk_data(0, 40);
    rk3[127:0] = k0; rd3[127:0] = d0; rv3 = 2'b01; sr3 = 2'b01;
    #1 chk("lat3_ready", 128'(rr3), 128'd1);
    @(negedge clk);
    rv3 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("lat3_core_data_hold", cdi3, d0);
      chk("lat3_no_early_valid", 128'(sv3), 128'd0);
      @(negedge clk);
    end
    chk("lat3_rsp_valid", 128'(sv3), 128'd1);
    chk("lat3_rsp_data", sd3, core_model(k0, d0));
    @(negedge clk);
    chk("lat3_done", 128'(sv3), 128'd0);
    chk("lat3_idle", 128'(bsy3), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
